// File: rtl/cdc_sync_filter.sv
// cdc_sync_filter: multi-bit synchroniser for asynchronous inputs entering the
// clk domain. Each bit runs through a STAGES-deep flop chain, an optional
// per-bit stability filter (FILTER cycles), and an edge detector that produces
// single-cycle rise/fall pulses.
//
// Ports:
//   clk        destination clock
//   resetn     synchronous, active-low reset
//   data_in    asynchronous inputs, bits independent
//   sync_raw   last chain stage, unfiltered
//   data_out   synchronised, filtered value
//   rise_pulse 1-cycle pulse per bit on a data_out 0->1 transition
//   fall_pulse 1-cycle pulse per bit on a data_out 1->0 transition
//   change     OR of all rise and fall pulse bits
module cdc_sync_filter #(
   parameter int unsigned             WIDTH     = 8,
   parameter int unsigned             STAGES    = 2,
   parameter logic [WIDTH-1:0]        RESET_VAL = '0,
   parameter int unsigned             FILTER    = 0
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] sync_raw,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic             change
);

   // A single flop cannot resolve metastability; reject shallow chains.
   if (STAGES < 2) begin : g_bad_stages
      $error("cdc_sync_filter: STAGES must be at least 2");
   end

   logic [WIDTH-1:0] stage [STAGES];
   logic [WIDTH-1:0] hist;

   // Synchroniser chain
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int k = 0; k < STAGES; k++) begin
            stage[k] <= RESET_VAL;
         end
      end else begin
         stage[0] <= data_in;
         for (int k = 1; k < STAGES; k++) begin
            stage[k] <= stage[k-1];
         end
      end
   end

   assign sync_raw = stage[STAGES-1];

   if (FILTER == 0) begin : g_bypass
      assign data_out = sync_raw;
   end else begin : g_filter
      localparam int unsigned CNT_W = (FILTER + 1 > 2) ? $clog2(FILTER + 1) : 1;
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER - 1);

      logic [WIDTH-1:0] filt_q;
      logic [CNT_W-1:0] cnt [WIDTH];

      // Per-bit stability filter: a differing value must persist FILTER
      // consecutive cycles; any reversion restarts the count.
      always_ff @(posedge clk) begin
         if (!resetn) begin
            filt_q <= RESET_VAL;
            for (int i = 0; i < WIDTH; i++) begin
               cnt[i] <= '0;
            end
         end else begin
            for (int i = 0; i < WIDTH; i++) begin
               if (sync_raw[i] != filt_q[i]) begin
                  if (cnt[i] == CNT_MAX) begin
                     filt_q[i] <= sync_raw[i];
                     cnt[i]    <= '0;
                  end else begin
                     cnt[i] <= cnt[i] + CNT_W'(1);
                  end
               end else begin
                  cnt[i] <= '0;
               end
            end
         end
      end

      assign data_out = filt_q;
   end

   // Edge history; pulses are decoded from registers only, so glitch-free.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         hist <= RESET_VAL;
      end else begin
         hist <= data_out;
      end
   end

   assign rise_pulse = data_out & ~hist;
   assign fall_pulse = ~data_out & hist;
   assign change     = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_cdc_sync_filter.sv
// Bench for cdc_sync_filter: two instances (bypass and filtered) checked
// against a scoreboard of expected output transitions.
module tb_cdc_sync_filter;

   typedef struct packed {
      logic [31:0] at;
      logic [7:0]  rise;
      logic [7:0]  fall;
      logic [7:0]  val;
   } ev_t;

   localparam logic [7:0] RV_A = 8'hA5;
   localparam logic [7:0] RV_B = 8'h00;
   localparam int unsigned LAT_A = 2;      // STAGES=2, FILTER=0
   localparam int unsigned LAT_B = 7;      // STAGES=3, FILTER=4

   logic        clk = 1'b0;
   logic        rstn_a, rstn_b;
   logic [7:0]  din_a, din_b;
   logic [7:0]  raw_a, raw_b, dout_a, dout_b;
   logic [7:0]  rise_a, rise_b, fall_a, fall_b;
   logic        chg_a, chg_b;

   logic [31:0] cyc = 0;
   int          total = 0;
   int          bad = 0;
   bit          chk_en = 1'b0;
   logic [7:0]  exp_a, exp_b, prev_a, prev_b;
   ev_t         qa[$];
   ev_t         qb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cdc_sync_filter #(.WIDTH(8), .STAGES(2), .RESET_VAL(RV_A), .FILTER(0)) u_a (
      .clk(clk), .resetn(rstn_a), .data_in(din_a), .sync_raw(raw_a),
      .data_out(dout_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .change(chg_a)
   );

   cdc_sync_filter #(.WIDTH(8), .STAGES(3), .RESET_VAL(RV_B), .FILTER(4)) u_b (
      .clk(clk), .resetn(rstn_b), .data_in(din_b), .sync_raw(raw_b),
      .data_out(dout_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .change(chg_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive a held value and record the transition it must cause.
   task automatic drive_a(input logic [7:0] v);
      ev_t e;
      din_a = v;
      if (v != prev_a) begin
         e.at = cyc + LAT_A; e.rise = v & ~prev_a; e.fall = ~v & prev_a; e.val = v;
         qa.push_back(e);
      end
      prev_a = v;
   endtask

   task automatic drive_b(input logic [7:0] v);
      ev_t e;
      din_b = v;
      if (v != prev_b) begin
         e.at = cyc + LAT_B; e.rise = v & ~prev_b; e.fall = ~v & prev_b; e.val = v;
         qb.push_back(e);
      end
      prev_b = v;
   endtask

   // Sample away from the active edge; pop an event when its cycle arrives.
   always @(negedge clk) begin
      ev_t e;
      if (chk_en) begin
         while (qa.size() > 0 && qa[0].at < cyc) begin
            check("a_late", cyc, qa[0].at);
            void'(qa.pop_front());
         end
         if (qa.size() > 0 && qa[0].at == cyc) begin
            e = qa.pop_front();
            exp_a = e.val;
            check("a_rise", 32'(rise_a), 32'(e.rise));
            check("a_fall", 32'(fall_a), 32'(e.fall));
            check("a_chg", 32'(chg_a), 32'd1);
         end else begin
            check("a_rise_idle", 32'(rise_a), 32'd0);
            check("a_fall_idle", 32'(fall_a), 32'd0);
            check("a_chg_idle", 32'(chg_a), 32'd0);
         end
         check("a_out", 32'(dout_a), 32'(exp_a));

         while (qb.size() > 0 && qb[0].at < cyc) begin
            check("b_late", cyc, qb[0].at);
            void'(qb.pop_front());
         end
         if (qb.size() > 0 && qb[0].at == cyc) begin
            e = qb.pop_front();
            exp_b = e.val;
            check("b_rise", 32'(rise_b), 32'(e.rise));
            check("b_fall", 32'(fall_b), 32'(e.fall));
            check("b_chg", 32'(chg_b), 32'd1);
         end else begin
            check("b_rise_idle", 32'(rise_b), 32'd0);
            check("b_fall_idle", 32'(fall_b), 32'd0);
            check("b_chg_idle", 32'(chg_b), 32'd0);
         end
         check("b_out", 32'(dout_b), 32'(exp_b));
      end
   end

   initial begin
      rstn_a = 1'b0; rstn_b = 1'b0;
      din_a = RV_A; din_b = RV_B;
      prev_a = RV_A; prev_b = RV_B;
      exp_a = RV_A; exp_b = RV_B;
      step(3);
      chk_en = 1'b1;
      step(1);
      rstn_a = 1'b1; rstn_b = 1'b1;
      step(20);                         // idle with data_in = reset value

      // Bypass instance: latency, multi-bit simultaneous edges, random levels
      drive_a(8'h00); step(6);
      drive_a(8'h01); step(6);
      drive_a(8'h0F); step(6);
      drive_a(8'hF0); step(6);
      for (int i = 0; i < 8; i++) begin
         drive_a(8'($urandom));
         step(4);
      end

      // Filtered instance: pass, 3-cycle glitch, 4-cycle pulse
      drive_b(8'h08); step(12);
      din_b = 8'h0C; step(3);
      din_b = 8'h08; step(14);
      drive_b(8'h0C); step(4);
      drive_b(8'h08); step(14);

      // Reset while bit 0 is mid-filter (cnt reaches 2 after 5 edges)
      drive_b(8'h09); step(5);
      rstn_b = 1'b0; step(1);
      qb.delete();
      exp_b = RV_B; prev_b = RV_B;
      step(2);
      rstn_b = 1'b1;
      drive_b(8'h09);
      step(14);

      check("qa_empty", 32'(qa.size()), 32'd0);
      check("qb_empty", 32'(qb.size()), 32'd0);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
